// File: rtl/ws2812_framebuffer_if.sv
// rtl/ws2812_framebuffer_if.sv - driver read port and writer/commit port of the ws2812 framebuffer
interface ws2812_framebuffer_if #(
    parameter int ADDR_BITS = 3
);
    logic [ADDR_BITS-1:0] address;
    logic                 new_address;
    logic [7:0]           red;
    logic [7:0]           green;
    logic [7:0]           blue;

    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [7:0]           wr_red;
    logic [7:0]           wr_green;
    logic [7:0]           wr_blue;

    logic                 commit;
    logic                 commit_pending;
    logic [7:0]           frame_count;

    modport master (
        output address, new_address, wr_valid, wr_addr, wr_red, wr_green, wr_blue, commit,
        input  red, green, blue, wr_ready, commit_pending, frame_count
    );

    modport slave (
        input  address, new_address, wr_valid, wr_addr, wr_red, wr_green, wr_blue, commit,
        output red, green, blue, wr_ready, commit_pending, frame_count
    );
endinterface

// File: rtl/ws2812_framebuffer.sv
// rtl/ws2812_framebuffer.sv - double-buffered pixel store feeding ws2812c, swaps only at frame start
// Optional FB_BRIGHTNESS_EN adds a brightness port and a scaling stage on the read path.
module ws2812_framebuffer #(
    parameter int NUM_LEDS  = 8,
    parameter int ADDR_BITS = 3
) (
    input  logic clk,
    input  logic reset,
`ifdef FB_BRIGHTNESS_EN
    input  logic [3:0] brightness,
`endif
    ws2812_framebuffer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_PENDING
    } state_t;

    localparam logic [ADDR_BITS:0]   LED_LIMIT = (ADDR_BITS + 1)'(NUM_LEDS);
    localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'(NUM_LEDS - 1);

    state_t               state;
    state_t               state_next;
    logic [ADDR_BITS-1:0] clr_idx;
    logic                 front;
    logic                 front_next;
    logic                 swap;
    logic                 wr_fire;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic [7:0]           frame_count_q;
    logic [23:0]          rd_q;
    logic [23:0]          pix_out;
    logic [23:0]          mem [2][NUM_LEDS];

    always_comb begin
        state_next = state;
        swap       = 1'b0;
        case (state)
            ST_CLEAR:   if (clr_idx == LAST_IDX) state_next = ST_RUN;
            ST_RUN:     if (bus.commit) state_next = ST_PENDING;
            ST_PENDING: begin
                if (bus.new_address && bus.address == '0) begin
                    swap       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default:    state_next = ST_CLEAR;
        endcase
    end

    // The read in the swap cycle already targets the newly committed bank.
    assign front_next  = front ^ swap;
    assign wr_fire     = bus.wr_valid && bus.wr_ready && reset;
    assign wr_in_range = {1'b0, bus.wr_addr} < LED_LIMIT;
    assign rd_in_range = {1'b0, bus.address} < LED_LIMIT;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_CLEAR;
            clr_idx       <= '0;
            front         <= 1'b0;
            frame_count_q <= 8'd0;
            rd_q          <= 24'd0;
        end else begin
            state <= state_next;
            front <= front_next;
            if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
            if (swap) frame_count_q <= frame_count_q + 8'd1;
            if (state != ST_CLEAR && bus.new_address)
                rd_q <= rd_in_range ? mem[front_next][bus.address] : 24'd0;
        end
    end

    // Out-of-range writes complete the handshake but store nothing.
    always_ff @(posedge clk) begin
        if (reset && state == ST_CLEAR) begin
            mem[0][clr_idx] <= 24'd0;
            mem[1][clr_idx] <= 24'd0;
        end else if (wr_fire && wr_in_range) begin
            mem[~front][bus.wr_addr] <= {bus.wr_red, bus.wr_green, bus.wr_blue};
        end
    end

`ifdef FB_BRIGHTNESS_EN
    logic [4:0]  gain;
    logic [23:0] scaled_q;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [4:0] g);
        logic [11:0] p;
        p = 12'(c) * 12'(g);
        return p[11:4];
    endfunction

    assign gain = {1'b0, brightness} + 5'd1;

    always_ff @(posedge clk) begin
        if (!reset) scaled_q <= 24'd0;
        else        scaled_q <= {scale(rd_q[23:16], gain), scale(rd_q[15:8], gain), scale(rd_q[7:0], gain)};
    end

    assign pix_out = scaled_q;
`else
    assign pix_out = rd_q;
`endif

    assign bus.red            = pix_out[23:16];
    assign bus.green          = pix_out[15:8];
    assign bus.blue           = pix_out[7:0];
    assign bus.wr_ready       = (state == ST_RUN);
    assign bus.commit_pending = (state == ST_PENDING);
    assign bus.frame_count    = frame_count_q;
endmodule

// File: tb/tb_ws2812_framebuffer.sv
// tb/tb_ws2812_framebuffer.sv - scoreboard bench for ws2812_framebuffer
module tb_ws2812_framebuffer;
`ifdef FB_BRIGHTNESS_EN
    localparam int LAT = 2;
    logic [3:0] brightness;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [23:0] exp_q[$];
    logic [1:0]  hist;

    ws2812_framebuffer_if #(.ADDR_BITS(3)) bus ();

    ws2812_framebuffer #(.NUM_LEDS(8), .ADDR_BITS(3)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef FB_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read monitor: output is due LAT cycles after the strobe was sampled.
    initial begin
        hist = 2'b00;
        forever begin
            @(negedge clk);
            if (hist[LAT-1]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_read", {8'd0, bus.red, bus.green, bus.blue}, 32'hdeadbeef);
                end else begin
                    check("pixel_read", {8'd0, bus.red, bus.green, bus.blue}, {8'd0, exp_q.pop_front()});
                end
            end
            hist = {hist[0], bus.new_address};
        end
    end

    task automatic strobe(input logic [2:0] a, input logic [23:0] exp);
        bus.address     = a;
        bus.new_address = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.new_address = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic sweep(input int lo, input int hi, input logic [23:0] p3);
        for (int i = lo; i <= hi; i++)
            strobe(3'(i), (i == 3) ? p3 : 24'd0);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.wr_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        check(name, {31'd0, bus.wr_ready}, 32'd1);
    endtask

    task automatic write_px(input logic [2:0] a, input logic [23:0] rgb, input logic do_commit);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        {bus.wr_red, bus.wr_green, bus.wr_blue} = rgb;
        bus.commit   = do_commit;
        wait_ready("write_ready");
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        bus.commit   = 1'b0;
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        wait_ready("commit_ready");
        @(posedge clk); #1;
        bus.commit = 1'b0;
    endtask

    task automatic check_clear_len(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.wr_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check(name, n, 8);
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b0;
        bus.address     = '0;
        bus.new_address = 1'b0;
        bus.wr_valid    = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_red      = '0;
        bus.wr_green    = '0;
        bus.wr_blue     = '0;
        bus.commit      = 1'b0;
`ifdef FB_BRIGHTNESS_EN
        brightness      = 4'd15;
`endif
        // 1: reset, CLEAR sweep, all-zero frame
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check_clear_len("clear_cycles");
        check("reset_pending", {31'd0, bus.commit_pending}, 32'd0);
        check("reset_frame_count", {24'd0, bus.frame_count}, 32'd0);
        @(posedge clk); #1;
        sweep(0, 7, 24'd0);

        // 2: back-buffer write is invisible before commit
        write_px(3'd3, 24'h060000, 1'b0);
        sweep(0, 7, 24'd0);

        // 3: commit mid-frame, swap at address 0
        write_px(3'd3, 24'h060000, 1'b0);
        sweep(0, 5, 24'd0);
        do_commit();
        @(negedge clk);
        check("pending_set", {31'd0, bus.commit_pending}, 32'd1);
        check("pending_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
        @(posedge clk); #1;
        sweep(6, 7, 24'd0);
        strobe(3'd0, 24'd0);
        check("swap1_frame_count", {24'd0, bus.frame_count}, 32'd1);
        check("swap1_pending", {31'd0, bus.commit_pending}, 32'd0);
        sweep(1, 7, 24'h060000);

        // 4: write and commit in the same cycle
        write_px(3'd3, 24'h112233, 1'b1);
        sweep(1, 7, 24'h060000);
        strobe(3'd0, 24'd0);
        check("swap2_frame_count", {24'd0, bus.frame_count}, 32'd2);
        sweep(1, 7, 24'h112233);

        // 5: second commit while pending is ignored; ping-pong back bank
        do_commit();
        bus.commit = 1'b1;
        @(posedge clk); #1;
        bus.commit = 1'b0;
        strobe(3'd0, 24'd0);
        check("swap3_frame_count", {24'd0, bus.frame_count}, 32'd3);
        sweep(1, 7, 24'h060000);
        strobe(3'd0, 24'd0);
        check("no_extra_swap", {24'd0, bus.frame_count}, 32'd3);
        check("no_extra_pending", {31'd0, bus.commit_pending}, 32'd0);

        // 5b: reset during PENDING
        do_commit();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("rst_pending_cleared", {31'd0, bus.commit_pending}, 32'd0);
        check_clear_len("reclear_cycles");
        check("rst_frame_count", {24'd0, bus.frame_count}, 32'd0);
        @(posedge clk); #1;
        sweep(0, 7, 24'd0);

        // 6: full-scale pixel through the read path
        write_px(3'd0, 24'hFFFFFF, 1'b1);
`ifdef FB_BRIGHTNESS_EN
        brightness = 4'd7;
        strobe(3'd0, 24'h7F7F7F);
`else
        strobe(3'd0, 24'hFFFFFF);
`endif
        check("swap4_frame_count", {24'd0, bus.frame_count}, 32'd1);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ws2812_framebuffer.md
Name: ws2812_framebuffer

Overview:
Double-buffered pixel store that sits directly upstream of the ws2812c driver and answers its address/new_address requests with red/green/blue values. Encoder/UI logic writes pixels into a back buffer through a valid/ready port and requests a commit. The block swaps front and back buffers only at a frame boundary, so the driver never shifts out a half-updated frame.

Parameters:
NUM_LEDS, 8, number of pixels per buffer (1..256)
ADDR_BITS, 3, width of address ports; must satisfy 2^ADDR_BITS >= NUM_LEDS

Ports:
clk  input  1  system clock (48 MHz HFOSC)
reset  input  1  synchronous, active-low reset
address  input  ADDR_BITS  pixel index requested by ws2812c
new_address  input  1  one-cycle strobe from ws2812c: address has changed
red  output  8  red value for current address
green  output  8  green value for current address
blue  output  8  blue value for current address
wr_valid  input  1  write request
wr_ready  output  1  write accepted when wr_valid && wr_ready
wr_addr  input  ADDR_BITS  back-buffer pixel index
wr_red  input  8  write data, red
wr_green  input  8  write data, green
wr_blue  input  8  write data, blue
commit  input  1  request swap at next frame start
commit_pending  output  1  high from accepted commit until swap
frame_count  output  8  count of completed swaps, wraps 255->0

Behaviour:
- Storage: two banks of NUM_LEDS x 24 bits. A 1-bit front pointer selects the bank the driver reads; the other bank is the back bank.
- Reset (reset==0 at a clk edge): FSM goes to CLEAR; clear index=0; front=0; commit_pending=0; frame_count=0; red/green/blue=0; wr_ready=0.
- FSM states:
  - CLEAR: writes zero to index i of both banks each cycle. After i==NUM_LEDS-1, go to RUN, so CLEAR lasts exactly NUM_LEDS cycles. wr_ready=0. Colour outputs are held at 0. new_address is ignored.
  - RUN: wr_ready=1. An accepted commit moves the FSM to PENDING and sets commit_pending=1 on the next cycle.
  - PENDING: wr_ready=0. On new_address && address==0: toggle front, clear commit_pending, increment frame_count, go to RUN.
- Read path:
  - On new_address, register the front-bank entry for address into red/green/blue.
  - Values are valid the cycle after the strobe, so read latency is 1.
  - Outputs hold between strobes.
  - If address >= NUM_LEDS, the outputs are 0.
- Swap/read ordering: in the swap cycle, the read uses the new front bank. Pixel 0 of the new frame comes from the newly committed data.
- Write path:
  - A write occurs when wr_valid && wr_ready, into back[wr_addr].
  - If wr_addr >= NUM_LEDS, the write is accepted (handshake completes) and the data is dropped.
- Write and commit in the same cycle: the write lands in the back bank before the swap, so it is included in the committed frame.
- commit while PENDING or CLEAR: ignored; no queueing.
- No copy on swap: after a swap the back bank holds the previous front frame (ping-pong). The writer must rewrite every pixel it needs changed.
- Reset mid-operation: any pending commit is lost, both banks are re-cleared, and front returns to 0.
- frame_count wraps modulo 256 silently.

Optional Feature:
FB_BRIGHTNESS_EN
- Defined:
  - Adds input port brightness (4 bits).
  - Adds one register stage on the read path: each channel output = (c * (brightness+1)) >> 4, computed at 12 bits and truncated to 8.
  - Read latency becomes 2 cycles after new_address.
  - brightness=15 passes values unchanged.
  - The stage resets to 0.
- Undefined: no brightness port, read latency 1, values passed unscaled.

Test Plan:
1. Reset low 2 cycles, then release -> wr_ready=0 for exactly NUM_LEDS(8) cycles then 1; strobe address 0..7 -> all colours 0; frame_count=0.
2. Write back[3]=(0x06,0x00,0x00) without commit; driver sweeps 0..7 -> address 3 still reads 0 (front untouched).
3. Write back[3], pulse commit mid-frame while driver is at address 5 -> commit_pending=1, wr_ready=0; addresses 6,7 still old; at address 0 strobe the swap occurs; address 3 reads 0x06/0/0; frame_count=1; commit_pending=0.
4. wr_valid with wr_addr=3 and commit in the same cycle -> the write is included; after the swap, address 3 returns the written value.
5. Second commit while PENDING -> ignored; one swap only; frame_count increments by 1. Pulse reset during PENDING -> commit_pending=0; the full CLEAR sweep repeats; all reads return 0.
6. With FB_BRIGHTNESS_EN, brightness=7, pixel 0xFF -> output 0x7F two cycles after new_address. Without the macro, 0xFF appears one cycle after the strobe.
